// File: rtl/dual_wavegen.sv
// dual_wavegen -- two-channel DDS waveform generator sharing one phase accumulator.
//
// A single phase accumulator advances by 'incr' on every enabled cycle.
// Channel 1 reads the phase directly. Channel 2 reads the same phase plus
// 'offset'. Each channel produces a sine, square, sawtooth or triangle
// sample. Both channels use one dual-read sine table.
//
// Pipeline (2 edges of latency):
//   stage 1 : register lane addresses, mode, en and the sine table reads
//   stage 2 : register the shaped samples into dout1/dout2 and valid
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   en      in   advance the phase by incr this cycle
//   sync    in   clear the phase this cycle (wins over en)
//   incr    in   [ADDRESS_WIDTH+FRAC_WIDTH] phase step
//   offset  in   [ADDRESS_WIDTH] channel-2 phase offset
//   mode    in   [2] 00 sine, 01 square, 10 sawtooth, 11 triangle
//   dout1   out  [DATA_WIDTH] channel-1 sample
//   dout2   out  [DATA_WIDTH] channel-2 sample
//   valid   out  samples come from a phase captured while en was high
//
// The sine table is computed during elaboration.
// The table uses mid-scale offset binary: round((2^DATA_WIDTH-1)/2*(1+sin)).
// The built-in table needs DATA_WIDTH <= 31 and ADDRESS_WIDTH <= 28.

module dual_wavegen_lane #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic [ADDRESS_WIDTH-1:0] a,
  input  logic [1:0]               mode,
  input  logic [DATA_WIDTH-1:0]    sine,
  output logic [DATA_WIDTH-1:0]    wave
);
  // Per-lane shaping. This logic is purely combinational.
  //   a    : stage-1 table address
  //   mode : waveform select
  //   sine : table entry read for address a
  //   wave : shaped sample
  localparam logic [1:0] M_SINE = 2'b00;
  localparam logic [1:0] M_SQR  = 2'b01;
  localparam logic [1:0] M_SAW  = 2'b10;

  logic [ADDRESS_WIDTH-1:0] tri_a;
  logic [DATA_WIDTH-1:0]    saw_w, tri_w;

  // Double the address to fold it into a rising ramp.
  // Invert the ramp in the second half of the period to make it fall.
  assign tri_a = {a[ADDRESS_WIDTH-2:0], 1'b0} ^ {ADDRESS_WIDTH{a[ADDRESS_WIDTH-1]}};

  // Align the address to the sample MSB.
  // Pad with zeros when the sample is wider, otherwise keep the top bits.
  if (DATA_WIDTH > ADDRESS_WIDTH) begin : g_pad
    assign saw_w = {a,     {(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}};
    assign tri_w = {tri_a, {(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}};
  end else begin : g_trunc
    assign saw_w = a[ADDRESS_WIDTH-1 -: DATA_WIDTH];
    assign tri_w = tri_a[ADDRESS_WIDTH-1 -: DATA_WIDTH];
  end

  always_comb begin
    wave = sine;
    case (mode)
      M_SINE:  wave = sine;
      M_SQR:   wave = {DATA_WIDTH{a[ADDRESS_WIDTH-1]}};
      M_SAW:   wave = saw_w;
      default: wave = tri_w;
    endcase
  end
endmodule

module dual_wavegen #(
  parameter int    ADDRESS_WIDTH = 8,
  parameter int    DATA_WIDTH    = 8,
  parameter int    FRAC_WIDTH    = 8,
  parameter string ROM_FILE      = "sinerom.mem"
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                sync,
  input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr,
  input  logic [ADDRESS_WIDTH-1:0]            offset,
  input  logic [1:0]                          mode,
  output logic [DATA_WIDTH-1:0]               dout1,
  output logic [DATA_WIDTH-1:0]               dout2,
  output logic                                valid
);
  localparam int NUM_LANES = 2;
  localparam int STAGES    = 2;
  localparam int PW        = ADDRESS_WIDTH + FRAC_WIDTH;
  localparam int DEPTH     = 1 << ADDRESS_WIDTH;

  // Fixed-point sine for one table entry.
  // The angle is reduced to the first quadrant.
  // A 13th-order Taylor series is evaluated in Q30.
  function automatic logic [DATA_WIDTH-1:0] sine_val(input int idx);
    longint q, r, k, x, x2, term, s, v, vmax;
    q    = longint'(idx) >> (ADDRESS_WIDTH - 2);
    r    = longint'(idx) & ((longint'(1) << (ADDRESS_WIDTH - 2)) - 1);
    k    = q[0] ? (longint'(1) << (ADDRESS_WIDTH - 2)) - r : r;
    x    = (k * 64'sd6746518852) >>> ADDRESS_WIDTH;  // k * 2*pi/DEPTH, Q30
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int n = 1; n <= 6; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    if (q[1]) s = -s;
    vmax = (longint'(1) << DATA_WIDTH) - 1;
    v    = (vmax * ((longint'(1) << 30) + s) + (longint'(1) << 30)) >>> 31;
    if (v > vmax) v = vmax;
    if (v < 0)    v = 0;
    return v[DATA_WIDTH-1:0];
  endfunction

  logic [PW-1:0]                               phase;
  logic [NUM_LANES-1:0][ADDRESS_WIDTH-1:0]     addr, a_s1;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]        rom_rd, sine_s1, wave, dout_q;
  logic [1:0]                                  mode_s1;
  logic [STAGES:1]                             vld_pipe;

  // Phase accumulator. It wraps silently modulo 2^PW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       phase <= '0;
    else if (sync) phase <= '0;
    else if (en)   phase <= phase + incr;
  end

  assign addr[0] = phase[PW-1 -: ADDRESS_WIDTH];
  assign addr[1] = addr[0] + offset;

  // Sine table: both lanes read one table through two read ports.
  // The read is registered in stage 1.
  logic [DATA_WIDTH-1:0] tab [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    localparam logic [DATA_WIDTH-1:0] SV = sine_val(k);
    assign tab[k] = SV;
  end
  always_comb
    for (int i = 0; i < NUM_LANES; i++) rom_rd[i] = tab[addr[i]];

  // Stage 1. These registers update every edge, so the pipeline keeps
  // running on a held phase when en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1    <= '0;
      sine_s1 <= '0;
      mode_s1 <= '0;
    end else begin
      a_s1    <= addr;
      sine_s1 <= rom_rd;
      mode_s1 <= mode;
    end
  end

  dual_wavegen_lane #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_lane [NUM_LANES-1:0] (
    .a    (a_s1),
    .mode ({NUM_LANES{mode_s1}}),
    .sine (sine_s1),
    .wave (wave)
  );

  // Stage 2 registers, plus the en shift register.
  // sync does not reach the en shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q   <= '0;
      vld_pipe <= '0;
    end else begin
      dout_q   <= wave;
      vld_pipe <= {vld_pipe[STAGES-1:1], en};
    end
  end

  assign dout1 = dout_q[0];
  assign dout2 = dout_q[1];
  assign valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_dual_wavegen.sv
module tb_dual_wavegen;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int FW = 8;

  logic        clk = 1'b0;
  logic        rst, en, sync;
  logic [15:0] incr;
  logic [7:0]  offset;
  logic [1:0]  mode;
  logic [7:0]  dout1, dout2;
  logic        valid;

  int total = 0;
  int bad   = 0;

  dual_wavegen #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_WIDTH(FW), .ROM_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .incr(incr),
    .offset(offset), .mode(mode), .dout1(dout1), .dout2(dout2), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model. It keeps the phase as a plain integer and records what
  // was presented at each edge. The outputs after an edge come from the
  // capture one edge earlier.
  typedef struct {
    bit [7:0] a1, a2;
    bit [1:0] mode;
    bit       en;
  } cap_t;
  cap_t        hist[$];
  int unsigned mp;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int shape(input int a, input int m);
    int t;
    case (m)
      1: return (a >= 128) ? 255 : 0;
      2: return a;
      3: begin
        t = (2 * a) % 256;
        return (a >= 128) ? 255 - t : t;
      end
      default: return -1;
    endcase
  endfunction

  task automatic chk_lane(input string nm, input int act, input int a, input int m);
    real ideal, diff;
    if (m == 0) begin
      ideal = 127.5 * (1.0 + $sin(2.0 * 3.14159265358979 * a / 256.0));
      diff  = real'(act) - ideal;
      if (diff < 0.0) diff = -diff;
      total++;
      if (diff > 1.0) begin
        bad++;
        $display("FAIL %s sine a=0x%0h: got %0d want ~%0.2f at %0t", nm, a, act, ideal, $time);
      end
    end else chk(nm, act, shape(a, m));
  endtask

  task automatic chk_model();
    if (hist.size() < 2) begin
      chk("m_rst_d1", dout1, 0);
      chk("m_rst_d2", dout2, 0);
      chk("m_rst_v",  valid, 0);
    end else begin
      chk("m_valid", valid, int'(hist[0].en));
      chk_lane("m_d1", dout1, hist[0].a1, hist[0].mode);
      chk_lane("m_d2", dout2, hist[0].a2, hist[0].mode);
    end
  endtask

  task automatic tick();
    cap_t c;
    c.a1   = mp[15:8];
    c.a2   = 8'(c.a1 + offset);
    c.mode = mode;
    c.en   = en;
    @(posedge clk);
    hist.push_back(c);
    if (hist.size() > 2) void'(hist.pop_front());
    if (sync)    mp = 0;
    else if (en) mp = (mp + incr) & 32'hFFFF;
    #1 chk_model();
  endtask

  // Called one time unit after a rising edge. The reset pulse lies entirely
  // between two edges, so it checks the asynchronous clear.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_d1", dout1, 0);
    chk("async_d2", dout2, 0);
    chk("async_v",  valid, 0);
    hist = {};
    mp   = 0;
    #2 rst = 1'b0;
  endtask

  task automatic set_in(input bit e, input bit s, input bit [15:0] inc,
                        input bit [7:0] off, input bit [1:0] m);
    en = e; sync = s; incr = inc; offset = off; mode = m;
  endtask

  typedef struct {
    bit        en, sync;
    bit [15:0] incr;
    bit [7:0]  off;
    bit [1:0]  mode;
    bit [7:0]  e1, e2;
    bit        ev;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 1'b0, 16'h0100, 8'h10, 2'd2, 8'h00, 8'h00, 1'b0};
    vt[1] = '{1'b1, 1'b0, 16'h0100, 8'h10, 2'd2, 8'h00, 8'h10, 1'b1};
    vt[2] = '{1'b1, 1'b0, 16'h0100, 8'h10, 2'd1, 8'h01, 8'h11, 1'b1};
    vt[3] = '{1'b1, 1'b0, 16'h0100, 8'h80, 2'd3, 8'h00, 8'h00, 1'b1};
    vt[4] = '{1'b0, 1'b0, 16'h0100, 8'h80, 2'd3, 8'h06, 8'hF9, 1'b1};
    vt[5] = '{1'b0, 1'b1, 16'h0100, 8'h80, 2'd3, 8'h08, 8'hF7, 1'b0};
    vt[6] = '{1'b1, 1'b0, 16'h0100, 8'h00, 2'd2, 8'h08, 8'hF7, 1'b0};
    vt[7] = '{1'b1, 1'b0, 16'h0100, 8'h00, 2'd2, 8'h00, 8'h00, 1'b1};
    vt[8] = '{1'b1, 1'b0, 16'h0100, 8'h00, 2'd2, 8'h01, 8'h01, 1'b1};

    rst = 1'b1;
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 2'd0);
    mp = 0;
    #1;
    chk("por_d1", dout1, 0);
    chk("por_d2", dout2, 0);
    chk("por_v",  valid, 0);
    @(posedge clk);
    #1 do_reset();

    // Vector table: each row is held for one edge, then checked.
    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].en, vt[i].sync, vt[i].incr, vt[i].off, vt[i].mode);
      tick();
      chk($sformatf("vec%0d_d1", i), dout1, vt[i].e1);
      chk($sformatf("vec%0d_d2", i), dout2, vt[i].e2);
      chk($sformatf("vec%0d_v",  i), valid, vt[i].ev);
    end

    // Sawtooth ramp through a full wrap.
    do_reset();
    set_in(1'b1, 1'b0, 16'h0100, 8'h00, 2'd2);
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (k >= 2) begin
        chk("saw_ramp", dout1, (k - 2) % 256);
        chk("saw_valid", valid, 1);
      end
    end

    // Fractional step: each value lasts two cycles.
    do_reset();
    set_in(1'b1, 1'b0, 16'h0080, 8'h00, 2'd2);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k >= 2) chk("saw_frac", dout1, (k - 2) / 2);
    end

    // Square wave in quadrature: channel 2 is the opposite level.
    do_reset();
    set_in(1'b1, 1'b0, 16'h0100, 8'h80, 2'd1);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k >= 2) begin
        chk("sq_d1", dout1, (((k - 2) % 256) >= 128) ? 255 : 0);
        chk("sq_d2", dout2, (((k - 2) % 256) >= 128) ? 0 : 255);
      end
    end

    // Sine with a quarter-period offset. The model checks both lanes.
    do_reset();
    set_in(1'b1, 1'b0, 16'h0100, 8'h40, 2'd0);
    for (int k = 1; k <= 258; k++) tick();

    // Triangle corner points.
    do_reset();
    set_in(1'b1, 1'b0, 16'h4000, 8'h00, 2'd3);
    for (int k = 1; k <= 5; k++) begin
      tick();
      case (k)
        2: chk("tri_00", dout1, 8'h00);
        3: chk("tri_40", dout1, 8'h80);
        4: chk("tri_80", dout1, 8'hFF);
        5: chk("tri_C0", dout1, 8'h7F);
        default: ;
      endcase
    end
    do_reset();
    set_in(1'b1, 1'b0, 16'hFF00, 8'h00, 2'd3);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) chk("tri_FF", dout1, 8'h01);
    end

    // sync together with en in the middle of a run.
    do_reset();
    set_in(1'b1, 1'b0, 16'h0100, 8'h00, 2'd2);
    for (int k = 1; k <= 10; k++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    chk("sync_pre", dout1, 8'h0A);
    chk("sync_v1",  valid, 1);
    tick();
    chk("sync_zero", dout1, 8'h00);
    chk("sync_v2",   valid, 1);

    // Asynchronous reset in the middle of a run, then a restart.
    for (int k = 1; k <= 5; k++) tick();
    do_reset();
    tick();
    chk("rr_v0", valid, 0);
    tick();
    chk("rr_d1", dout1, 8'h00);
    chk("rr_v1", valid, 1);

    // Randomized run against the model.
    for (int n = 0; n < 2000; n++) begin
      en   = ($urandom % 4) != 0;
      sync = ($urandom % 24) == 0;
      if ($urandom % 8 == 0) incr = ($urandom % 2) ? 16'($urandom) : 16'($urandom % 1024);
      if ($urandom % 4 == 0) offset = 8'($urandom);
      if ($urandom % 6 == 0) mode = 2'($urandom);
      tick();
      if ($urandom % 400 == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
